// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, CDB writeback, in-order retire with rollback.
// Optional ROB_COMMIT_COUNTER_EN adds a free-running commit counter on dbg_commit_cnt_out.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 5,
    parameter int PTR_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              alloc_valid_in,
    input  logic [4:0]        alloc_rd_in,
    input  logic              alloc_is_branch_in,
    input  logic [31:0]       alloc_pc_in,
    output logic [ID_W-1:0]   alloc_rob_id_out,
    output logic              full_out,
    input  logic              wb_valid_in,
    input  logic [ID_W-1:0]   wb_rob_id_in,
    input  logic [31:0]       wb_value_in,
    input  logic              wb_mispredict_in,
    input  logic [31:0]       wb_target_in,
    input  logic [ID_W-1:0]   q1_id_in,
    input  logic [ID_W-1:0]   q2_id_in,
    output logic              q1_ready_out,
    output logic              q2_ready_out,
    output logic [31:0]       q1_value_out,
    output logic [31:0]       q2_value_out,
    output logic              commit_flag_out,
    output logic [4:0]        commit_rd_out,
    output logic [31:0]       commit_value_out,
    output logic [ID_W-1:0]   commit_rob_id_out,
    output logic              rollback_flag_out,
    output logic [31:0]       rollback_pc_out
`ifdef ROB_COMMIT_COUNTER_EN
    ,
    output logic [31:0]       dbg_commit_cnt_out
`endif
);

    localparam logic [ID_W-1:0] MAX_ID   = ID_W'(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [DEPTH-1:0] br_q, br_d, mp_q, mp_d;
    logic [4:0]       rd_q     [DEPTH];
    logic [4:0]       rd_d     [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      value_d  [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      pc_d     [DEPTH];

    logic             commit_flag_q, commit_flag_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_value_q, commit_value_d;
    logic [ID_W-1:0]  commit_id_q, commit_id_d;
    logic             rollback_flag_q, rollback_flag_d;
    logic [31:0]      rollback_pc_q, rollback_pc_d;

    logic             full, do_alloc, do_wb, do_commit, flush;
    logic [PTR_W-1:0] wb_idx;

    assign full             = (count_q == FULL_CNT);
    assign full_out         = full;
    assign alloc_rob_id_out = ID_W'(tail_q) + ID_W'(1);

    assign wb_idx    = PTR_W'(wb_rob_id_in - ID_W'(1));
    assign do_alloc  = alloc_valid_in && !full && !rollback_flag_q;
    assign do_wb     = wb_valid_in && (wb_rob_id_in != '0) && (wb_rob_id_in <= MAX_ID)
                       && !rollback_flag_q && busy_q[wb_idx];
    assign do_commit = (count_q != '0) && ready_q[head_q] && !rollback_flag_q;
    assign flush     = do_commit && br_q[head_q] && mp_q[head_q];

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        br_d           = br_q;
        mp_d           = mp_q;
        rd_d           = rd_q;
        value_d        = value_q;
        target_d       = target_q;
        pc_d           = pc_q;
        commit_flag_d  = do_commit;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_id_d    = commit_id_q;
        rollback_flag_d = flush;
        rollback_pc_d  = rollback_pc_q;

        if (do_alloc) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            mp_d[tail_q]    = 1'b0;
            br_d[tail_q]    = alloc_is_branch_in;
            rd_d[tail_q]    = alloc_rd_in;
            pc_d[tail_q]    = alloc_pc_in;
            tail_d          = tail_q + PTR_W'(1);
        end

        if (do_wb) begin
            ready_d[wb_idx]  = 1'b1;
            value_d[wb_idx]  = wb_value_in;
            mp_d[wb_idx]     = wb_mispredict_in;
            target_d[wb_idx] = wb_target_in;
        end

        // Commit reads the registered head entry, so a same-cycle writeback never bypasses into it.
        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
            commit_rd_d    = rd_q[head_q];
            commit_value_d = value_q[head_q];
            commit_id_d    = ID_W'(head_q) + ID_W'(1);
        end

        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Flush overrides any same-cycle allocation: that instruction is on the wrong path.
        if (flush) begin
            busy_d        = '0;
            ready_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            rollback_pc_d = target_q[head_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            br_q            <= '0;
            mp_q            <= '0;
            commit_flag_q   <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_id_q     <= '0;
            rollback_flag_q <= 1'b0;
            rollback_pc_q   <= '0;
        end else if (rdy_in) begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            br_q            <= br_d;
            mp_q            <= mp_d;
            commit_flag_q   <= commit_flag_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_id_q     <= commit_id_d;
            rollback_flag_q <= rollback_flag_d;
            rollback_pc_q   <= rollback_pc_d;
        end else begin
            commit_flag_q   <= 1'b0;
            rollback_flag_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            rd_q     <= rd_d;
            value_q  <= value_d;
            target_q <= target_d;
            pc_q     <= pc_d;
        end
    end

    assign commit_flag_out   = commit_flag_q;
    assign commit_rd_out     = commit_rd_q;
    assign commit_value_out  = commit_value_q;
    assign commit_rob_id_out = commit_id_q;
    assign rollback_flag_out = rollback_flag_q;
    assign rollback_pc_out   = rollback_pc_q;

    // Returns {ready, value}; the CDB bypass takes priority over the stored entry.
    function automatic logic [32:0] query(input logic [ID_W-1:0] id);
        logic [PTR_W-1:0] idx;
        idx = PTR_W'(id - ID_W'(1));
        if (id == '0)
            return {1'b1, 32'h0};
        else if (wb_valid_in && (wb_rob_id_in == id))
            return {1'b1, wb_value_in};
        else if (id > MAX_ID)
            return {1'b0, 32'h0};
        else
            return {busy_q[idx] & ready_q[idx], value_q[idx]};
    endfunction

    always_comb begin
        {q1_ready_out, q1_value_out} = query(q1_id_in);
        {q2_ready_out, q2_value_out} = query(q2_id_in);
    end

`ifdef ROB_COMMIT_COUNTER_EN
    logic [31:0] commit_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            commit_cnt_q <= '0;
        else if (rdy_in && do_commit)
            commit_cnt_q <= commit_cnt_q + 32'd1;
    end

    assign dbg_commit_cnt_out = commit_cnt_q;
`endif

endmodule
